// File: rtl/vending_pkg.sv
// Shared types and coin decode for the vending change controller.
// Coin codes are one-hot; any other code decodes to zero cents.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    DISPENSE,
    CHANGE
  } states_t;

  localparam logic [3:0] COIN_25  = 4'b0001;
  localparam logic [3:0] COIN_50  = 4'b0010;
  localparam logic [3:0] COIN_75  = 4'b0100;
  localparam logic [3:0] COIN_100 = 4'b1000;

  localparam int COIN_UNIT = 25;

  function automatic logic [6:0] coin_value(
    input logic [3:0] coin
  );
    case (coin)
      COIN_25:  coin_value = 7'd25;
      COIN_50:  coin_value = 7'd50;
      COIN_75:  coin_value = 7'd75;
      COIN_100: coin_value = 7'd100;
      default:  coin_value = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_change_fsm.sv
// Moore vending controller: credit accumulation, one-cycle dispense,
// quarter-by-quarter change/refund through a hopper handshake.
module vending_change_fsm
  import vending_pkg::*;
#(
  parameter int PRICE    = 125,
  parameter int CREDIT_W = 8,
  parameter int SALES_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [3:0]          coin,
  input  logic                cancel,
  input  logic                change_ack,
  output logic                dispense,
  output logic                change_quarter,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic [SALES_W-1:0]  sales_count
);

  if ((PRICE % COIN_UNIT) != 0 || PRICE < COIN_UNIT) begin : g_bad_price
    $error("PRICE must be a positive multiple of 25");
  end
  if (CREDIT_W < 7 || CREDIT_W > 30 ||
      (PRICE + 75) >= (1 << CREDIT_W)) begin : g_bad_width
    $error("CREDIT_W cannot hold PRICE+75");
  end

  localparam logic [CREDIT_W-1:0] LP_PRICE = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] LP_UNIT  = CREDIT_W'(COIN_UNIT);

  states_t               r_state;
  states_t               w_state_n;
  logic [CREDIT_W-1:0]   r_credit;
  logic [CREDIT_W-1:0]   w_credit_n;
  logic [SALES_W-1:0]    r_sales;
  logic                  r_reject;
  logic [CREDIT_W-1:0]   w_coin;
  logic [CREDIT_W-1:0]   w_sum;
  logic [CREDIT_W-1:0]   w_remain;
  logic                  w_legal;
  logic                  w_busy;
  logic                  w_cancel;
  logic                  w_accept;
  logic                  w_reject;

  assign w_coin   = CREDIT_W'(coin_value(coin));
  assign w_legal  = coin_valid && (w_coin != '0);
  assign w_sum    = r_credit + w_coin;
  assign w_remain = r_credit - LP_PRICE;
  assign w_busy   = (r_state == DISPENSE) || (r_state == CHANGE);
  assign w_cancel = (r_state == CREDIT) && cancel;
  assign w_accept = w_legal && !w_busy && !w_cancel;
  assign w_reject = coin_valid && !w_accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE, CREDIT: begin
        if (w_cancel) begin
          w_state_n = CHANGE;
        end else if (w_accept) begin
          w_state_n = (w_sum >= LP_PRICE) ? DISPENSE : CREDIT;
        end
      end
      DISPENSE: w_state_n = (w_remain != '0) ? CHANGE : IDLE;
      CHANGE: begin
        if (change_ack && r_credit == LP_UNIT) begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Credit only moves on an accepted coin, the sale, or a paid quarter.
  always_comb begin
    w_credit_n = r_credit;
    case (r_state)
      IDLE, CREDIT: if (w_accept) w_credit_n = w_sum;
      DISPENSE:     w_credit_n = w_remain;
      CHANGE:       if (change_ack) w_credit_n = r_credit - LP_UNIT;
      default:      w_credit_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_credit <= '0;
      r_sales  <= '0;
      r_reject <= 1'b0;
    end else begin
      r_credit <= w_credit_n;
      r_reject <= w_reject;
      if (r_state == DISPENSE) begin
        r_sales <= r_sales + 1'b1;
      end
    end
  end

  always_comb begin
    dispense       = (r_state == DISPENSE);
    change_quarter = (r_state == CHANGE);
    busy           = w_busy;
    coin_reject    = r_reject;
    credit         = r_credit;
    sales_count    = r_sales;
  end

endmodule

// File: tb/tb_vending_change_fsm.sv
// Directed bench for vending_change_fsm (PRICE=125, SALES_W=2).
// Expected outputs are queued per step and popped after the edge.
module tb_vending_change_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_valid = 1'b0;
  logic [3:0] coin = 4'b0000;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic       dispense;
  logic       change_quarter;
  logic       coin_reject;
  logic [7:0] credit;
  logic       busy;
  logic [1:0] sales_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [7:0] credit;
    logic       disp;
    logic       cq;
    logic       rej;
    logic       busy;
    logic [1:0] sales;
  } exp_t;

  exp_t sb[$];

  vending_change_fsm #(
    .PRICE(125),
    .CREDIT_W(8),
    .SALES_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .coin_valid(coin_valid),
    .coin(coin),
    .cancel(cancel),
    .change_ack(change_ack),
    .dispense(dispense),
    .change_quarter(change_quarter),
    .coin_reject(coin_reject),
    .credit(credit),
    .busy(busy),
    .sales_count(sales_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(
    input string tag,
    input logic cv, input logic [3:0] c,
    input logic can, input logic ack,
    input int e_cr, input logic e_d, input logic e_cq,
    input logic e_rej, input logic e_b, input int e_s
  );
    exp_t e;
    exp_t g;
    e.tag = tag; e.credit = 8'(e_cr); e.disp = e_d; e.cq = e_cq;
    e.rej = e_rej; e.busy = e_b; e.sales = 2'(e_s);
    coin_valid = cv; coin = c; cancel = can; change_ack = ack;
    sb.push_back(e);
    @(posedge clk);
    #1;
    coin_valid = 1'b0; coin = 4'b0000; cancel = 1'b0; change_ack = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      g = sb.pop_front();
      chk({g.tag, "_credit"}, int'(credit), int'(g.credit));
      chk({g.tag, "_disp"}, int'(dispense), int'(g.disp));
      chk({g.tag, "_cq"}, int'(change_quarter), int'(g.cq));
      chk({g.tag, "_rej"}, int'(coin_reject), int'(g.rej));
      chk({g.tag, "_busy"}, int'(busy), int'(g.busy));
      chk({g.tag, "_sales"}, int'(sales_count), int'(g.sales));
    end
  endtask

  initial begin
    // reset held low two cycles
    reset = 1'b0;
    step("rst0", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst1", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("idle", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

    // exact pay
    step("ex100", 1, 4'b1000, 0, 0, 100, 0, 0, 0, 0, 0);
    step("ex25", 1, 4'b0001, 0, 0, 125, 1, 0, 0, 1, 0);
    step("exdone", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("exidle", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1);

    // overpay, immediate acks
    step("ov75", 1, 4'b0100, 0, 0, 75, 0, 0, 0, 0, 1);
    step("ov100", 1, 4'b1000, 0, 0, 175, 1, 0, 0, 1, 1);
    step("ovchg", 0, 4'h0, 0, 0, 50, 0, 1, 0, 1, 2);
    step("ovack1", 0, 4'h0, 0, 1, 25, 0, 1, 0, 1, 2);
    step("ovack2", 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 2);

    // overpay, acks delayed three cycles
    step("dl75", 1, 4'b0100, 0, 0, 75, 0, 0, 0, 0, 2);
    step("dl100", 1, 4'b1000, 0, 0, 175, 1, 0, 0, 1, 2);
    step("dlchg", 0, 4'h0, 0, 0, 50, 0, 1, 0, 1, 3);
    for (int i = 0; i < 3; i++)
      step("dlwait1", 0, 4'h0, 0, 0, 50, 0, 1, 0, 1, 3);
    step("dlack1", 0, 4'h0, 0, 1, 25, 0, 1, 0, 1, 3);
    for (int i = 0; i < 3; i++)
      step("dlwait2", 0, 4'h0, 0, 0, 25, 0, 1, 0, 1, 3);
    step("dlack2", 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 3);

    // cancel refund
    step("cn50", 1, 4'b0010, 0, 0, 50, 0, 0, 0, 0, 3);
    step("cn25", 1, 4'b0001, 0, 0, 75, 0, 0, 0, 0, 3);
    step("cncan", 0, 4'h0, 1, 0, 75, 0, 1, 0, 1, 3);
    step("cnack1", 0, 4'h0, 0, 1, 50, 0, 1, 0, 1, 3);
    step("cnack2", 0, 4'h0, 0, 1, 25, 0, 1, 0, 1, 3);
    step("cnack3", 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 3);

    // illegal codes, idle cancel and stray ack
    step("rj0011", 1, 4'b0011, 0, 0, 0, 0, 0, 1, 0, 3);
    step("rjclr", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 3);
    step("rj0000", 1, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 3);
    step("idlecan", 0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 3);
    step("idleack", 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 3);
    step("mb25", 1, 4'b0001, 0, 0, 25, 0, 0, 0, 0, 3);
    step("mb1100", 1, 4'b1100, 0, 0, 25, 0, 0, 1, 0, 3);
    step("mbcan", 0, 4'h0, 1, 0, 25, 0, 1, 0, 1, 3);
    step("mback", 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 3);

    // coin during CHANGE; fourth sale wraps the counter
    step("wc100", 1, 4'b1000, 0, 0, 100, 0, 0, 0, 0, 3);
    step("wc75", 1, 4'b0100, 0, 0, 175, 1, 0, 0, 1, 3);
    step("wcwrap", 0, 4'h0, 0, 0, 50, 0, 1, 0, 1, 0);
    step("wccoin", 1, 4'b0001, 0, 0, 50, 0, 1, 1, 1, 0);
    step("wcack1", 0, 4'h0, 0, 1, 25, 0, 1, 0, 1, 0);
    step("wcack2", 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0);

    // cancel and coin together in CREDIT
    step("cc50", 1, 4'b0010, 0, 0, 50, 0, 0, 0, 0, 0);
    step("ccboth", 1, 4'b0001, 1, 0, 50, 0, 1, 1, 1, 0);
    step("ccack1", 0, 4'h0, 0, 1, 25, 0, 1, 0, 1, 0);
    step("ccack2", 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0);

    // reset mid-change
    step("rc100", 1, 4'b1000, 0, 0, 100, 0, 0, 0, 0, 0);
    step("rc75", 1, 4'b0100, 0, 0, 175, 1, 0, 0, 1, 0);
    step("rcchg", 0, 4'h0, 0, 0, 50, 0, 1, 0, 1, 1);
    reset = 1'b0;
    step("rcrst", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("rcidle", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset mid-vend
    step("rv100", 1, 4'b1000, 0, 0, 100, 0, 0, 0, 0, 0);
    step("rv25", 1, 4'b0001, 0, 0, 125, 1, 0, 0, 1, 0);
    reset = 1'b0;
    step("rvrst", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("rvidle", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
